// File: rtl/hazard_stall_unit_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard/stall unit (slave).
interface hazard_stall_unit_if #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 32
);
    logic [WIDTH-1:0] ID_rs1;
    logic [WIDTH-1:0] ID_rs2;
    logic             ID_use_rs1;
    logic             ID_use_rs2;
    logic             EX_MemRead;
    logic             EX_RegWrite;
    logic [WIDTH-1:0] EX_rd;
    logic             EX_redirect;
    // Memory handshake: MEM_req is held high by MEM for as long as its access is
    // outstanding; the access completes in the cycle MEM_ready is 1. Every cycle
    // with MEM_req=1 and MEM_ready=0 freezes the whole pipeline.
    logic             MEM_req;
    logic             MEM_ready;
    logic             PC_stall;
    logic             IFID_stall;
    logic             IFID_flush;
    logic             IDEX_stall;
    logic             IDEX_flush;
    logic             EXMEM_stall;
    logic             MEMWB_flush;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;
    logic             dbg_memwait;

    modport master (
        output ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2,
        output EX_MemRead, EX_RegWrite, EX_rd, EX_redirect,
        output MEM_req, MEM_ready,
        input  PC_stall, IFID_stall, IFID_flush, IDEX_stall, IDEX_flush,
        input  EXMEM_stall, MEMWB_flush, mem_err, stall_cycles, flush_events,
        input  dbg_memwait
    );

    modport slave (
        input  ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2,
        input  EX_MemRead, EX_RegWrite, EX_rd, EX_redirect,
        input  MEM_req, MEM_ready,
        output PC_stall, IFID_stall, IFID_flush, IDEX_stall, IDEX_flush,
        output EXMEM_stall, MEMWB_flush, mem_err, stall_cycles, flush_events,
        output dbg_memwait
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Five-stage pipeline hazard unit: memory freeze, redirect flush, load-use stall, memory timeout.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_unit #(
    parameter int WIDTH   = 5,
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 32
) (
    input logic                clk,
    input logic                rst,
    hazard_stall_unit_if.slave hif
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
    localparam logic [WIDTH-1:0]  REG_ZERO = '0;

    typedef enum logic {RUN = 1'b0, MEMWAIT = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;
    logic              freeze, load_use;
    logic              pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
    logic              exmem_stall, memwb_flush;

    always_comb begin
        freeze   = hif.MEM_req & ~hif.MEM_ready;
        load_use = hif.EX_MemRead & hif.EX_RegWrite & (hif.EX_rd != REG_ZERO) &
                   ((hif.ID_use_rs1 & (hif.ID_rs1 == hif.EX_rd)) |
                    (hif.ID_use_rs2 & (hif.ID_rs2 == hif.EX_rd)));
    end

    // A redirect seen during a freeze is ignored here; EX holds it and re-presents it afterwards.
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_stall  = 1'b0;
        idex_flush  = 1'b0;
        exmem_stall = 1'b0;
        memwb_flush = 1'b0;
        if (!rst) begin
            if (freeze) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_stall  = 1'b1;
                exmem_stall = 1'b1;
                memwb_flush = 1'b1;
            end else if (hif.EX_redirect) begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
            end else if (load_use) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_flush  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q | (wait_cnt_q == WAIT_MAX);
        case (state_q)
            RUN: begin
                if (freeze) begin
                    state_d    = MEMWAIT;
                    wait_cnt_d = '0;
                end
            end
            MEMWAIT: begin
                // Leaving on MEM_ready or on MEM_req dropping; the count restarts at zero.
                if (!freeze) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q != WAIT_MAX) begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign hif.PC_stall    = pc_stall;
    assign hif.IFID_stall  = ifid_stall;
    assign hif.IFID_flush  = ifid_flush;
    assign hif.IDEX_stall  = idex_stall;
    assign hif.IDEX_flush  = idex_flush;
    assign hif.EXMEM_stall = exmem_stall;
    assign hif.MEMWB_flush = memwb_flush;
    assign hif.mem_err     = mem_err_q & ~rst;
    assign hif.dbg_memwait = (state_q == MEMWAIT) & ~rst;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pc_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (idex_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hif.stall_cycles = rst ? '0 : stall_cnt_q;
    assign hif.flush_events = rst ? '0 : flush_cnt_q;
`else
    assign hif.stall_cycles = {CNT_W{1'b0}};
    assign hif.flush_events = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: directed scenarios then random traffic against a reference model.
module tb_hazard_stall_unit;
    localparam int WIDTH   = 5;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 32;
    localparam int EW      = 7 + 1 + 1 + 2 * CNT_W;
    localparam longint CMAX = (longint'(1) << CNT_W) - 1;

    typedef struct {
        logic             rst;
        logic [WIDTH-1:0] rs1, rs2, rd;
        logic             use1, use2, memread, regwrite, redirect, req, ready;
    } stim_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_stall_unit_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) hif ();

    hazard_stall_unit #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hif (hif.slave)
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // reference model: pipeline view of the memory wait and the counters
    bit     m_wait   = 0;
    int     m_waited = 0;
    bit     m_err    = 0;
    longint m_stall  = 0;
    longint m_flush  = 0;

    function automatic stim_t idle();
        stim_t s;
        s.rst = 0; s.rs1 = '0; s.rs2 = '0; s.rd = '0;
        s.use1 = 0; s.use2 = 0; s.memread = 0; s.regwrite = 0;
        s.redirect = 0; s.req = 0; s.ready = 0;
        return s;
    endfunction

    function automatic stim_t load_hit(input logic [WIDTH-1:0] rd, input bit on_rs2);
        stim_t s = idle();
        s.memread = 1; s.regwrite = 1; s.rd = rd;
        if (on_rs2) begin s.rs2 = rd; s.use2 = 1; end
        else        begin s.rs1 = rd; s.use1 = 1; end
        return s;
    endfunction

    function automatic stim_t mem(input bit req, input bit ready);
        stim_t s = idle();
        s.req = req; s.ready = ready;
        return s;
    endfunction

    // ---------------- driver ----------------
    task automatic issue(input stim_t s);
        bit freeze, lu;
        logic [6:0] ctrl;
        @(posedge clk); #1;
        rst             = s.rst;
        hif.ID_rs1      = s.rs1;      hif.ID_rs2      = s.rs2;
        hif.ID_use_rs1  = s.use1;     hif.ID_use_rs2  = s.use2;
        hif.EX_MemRead  = s.memread;  hif.EX_RegWrite = s.regwrite;
        hif.EX_rd       = s.rd;       hif.EX_redirect = s.redirect;
        hif.MEM_req     = s.req;      hif.MEM_ready   = s.ready;

        freeze = s.req && !s.ready;
        lu = s.memread && s.regwrite && (s.rd != 0) &&
             ((s.use1 && s.rs1 == s.rd) || (s.use2 && s.rs2 == s.rd));
        // ctrl order: PC_stall IFID_stall IFID_flush IDEX_stall IDEX_flush EXMEM_stall MEMWB_flush
        ctrl = 7'b0000000;
        if (!s.rst) begin
            if (freeze)          ctrl = 7'b1101011;
            else if (s.redirect) ctrl = 7'b0010100;
            else if (lu)         ctrl = 7'b1100100;
        end
        if (s.rst) exp_q.push_back({ctrl, 1'b0, 1'b0, {CNT_W{1'b0}}, {CNT_W{1'b0}}});
        else       exp_q.push_back({ctrl, m_err, m_wait, CNT_W'(m_stall), CNT_W'(m_flush)});

        if (s.rst) begin
            m_wait = 0; m_waited = 0; m_err = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (m_waited == TIMEOUT) m_err = 1;
            if (m_wait && freeze) m_waited = (m_waited < TIMEOUT) ? m_waited + 1 : TIMEOUT;
            else                  m_waited = 0;
            m_wait = freeze;
`ifdef HAZARD_PERF_CNT_EN
            if (ctrl[6] && m_stall < CMAX) m_stall++;
            if (ctrl[2] && m_flush < CMAX) m_flush++;
`endif
        end
    endtask

    task automatic do_reset(input int n);
        stim_t s = idle();
        s.rst = 1;
        repeat (n) issue(s);
    endtask

    // ---------------- monitor ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [EW-1:0] e;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ctrl", 64'({hif.PC_stall, hif.IFID_stall, hif.IFID_flush, hif.IDEX_stall,
                               hif.IDEX_flush, hif.EXMEM_stall, hif.MEMWB_flush}), 64'(e[EW-1 -: 7]));
            check("mem_err", 64'(hif.mem_err), 64'(e[2*CNT_W+1]));
            check("memwait", 64'(hif.dbg_memwait), 64'(e[2*CNT_W]));
            check("stall_cycles", 64'(hif.stall_cycles), 64'(e[2*CNT_W-1 -: CNT_W]));
            check("flush_events", 64'(hif.flush_events), 64'(e[CNT_W-1:0]));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        stim_t s;
        s = idle();
        hif.ID_rs1 = '0; hif.ID_rs2 = '0; hif.ID_use_rs1 = 0; hif.ID_use_rs2 = 0;
        hif.EX_MemRead = 0; hif.EX_RegWrite = 0; hif.EX_rd = '0; hif.EX_redirect = 0;
        hif.MEM_req = 0; hif.MEM_ready = 0;

        do_reset(2);
        // reset forces controls off even with every hazard present
        s = load_hit(5'd5, 0); s.rst = 1; s.req = 1; s.redirect = 1; issue(s);

        // load-use on rs1 then rs2, then release
        issue(load_hit(5'd5, 0)); issue(idle());
        issue(load_hit(5'd9, 1)); issue(idle());
        // no stall: x0 destination, operand not used, not a load
        issue(load_hit(5'd0, 0));
        s = load_hit(5'd5, 0); s.use1 = 0; issue(s);
        s = load_hit(5'd5, 0); s.memread = 0; issue(s);
        // redirect beats load-use
        s = load_hit(5'd5, 0); s.redirect = 1; issue(s);

        // short memory wait: 3 frozen cycles then ready
        repeat (3) issue(mem(1, 0));
        issue(mem(1, 1)); issue(idle());
        // redirect held through a freeze only flushes once ready arrives
        s = mem(1, 0); s.redirect = 1; issue(s); issue(s);
        s = mem(1, 1); s.redirect = 1; issue(s); issue(idle());
        // MEM_req withdrawn while waiting
        repeat (3) issue(mem(1, 0));
        issue(mem(0, 0)); issue(idle());

        // timeout: mem_err sticks past ready until reset
        repeat (10) issue(mem(1, 0));
        issue(mem(1, 1)); issue(idle()); issue(idle());
        // reset in the middle of a wait
        repeat (2) issue(mem(1, 0));
        do_reset(1);
        issue(mem(1, 0)); issue(mem(1, 1)); issue(idle());

        // counter scenario: 3 load-use stalls and 2 redirects, then a reset pulse
        do_reset(1);
        repeat (3) begin issue(load_hit(5'd7, 0)); issue(idle()); end
        s = idle(); s.redirect = 1; issue(s); issue(idle()); issue(s);
        issue(idle());
        do_reset(1);
        issue(idle());

        // random traffic with small register ranges to provoke collisions
        repeat (600) begin
            s.rst      = ($urandom_range(0, 63) == 0);
            s.rs1      = WIDTH'($urandom_range(0, 3));
            s.rs2      = WIDTH'($urandom_range(0, 3));
            s.rd       = WIDTH'($urandom_range(0, 3));
            s.use1     = 1'($urandom_range(0, 1));
            s.use2     = 1'($urandom_range(0, 1));
            s.memread  = 1'($urandom_range(0, 1));
            s.regwrite = ($urandom_range(0, 3) != 0);
            s.redirect = ($urandom_range(0, 3) == 0);
            s.req      = 1'($urandom_range(0, 1));
            s.ready    = ($urandom_range(0, 2) == 0);
            issue(s);
        end

        @(posedge clk); @(negedge clk); #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end
endmodule

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 5: register-address width.
REQ-002 SHALL have parameter TIMEOUT, default 256: memory-wait cycles before mem_err is raised (legal range 1..65535).
REQ-003 SHALL have parameter CNT_W, default 32: performance-counter width.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports ID_rs1, ID_rs2  in  WIDTH  source registers of the instruction in ID.
REQ-007 SHALL have ports ID_use_rs1, ID_use_rs2  in  1  ID instruction actually reads rs1/rs2.
REQ-008 SHALL have ports EX_MemRead, EX_RegWrite  in  1  and EX_rd  in  WIDTH: EX-stage load flag, write-enable and destination.
REQ-009 SHALL have port EX_redirect  in  1  branch/jump taken, resolved in EX.
REQ-010 SHALL have ports MEM_req, MEM_ready  in  1  data-memory access in MEM, and memory completion.
REQ-011 SHALL have outputs PC_stall, IFID_stall, IFID_flush, IDEX_stall, IDEX_flush, EXMEM_stall, MEMWB_flush  out  1  pipeline-register controls.
REQ-012 SHALL have output mem_err  out  1  sticky memory-timeout flag.
REQ-013 SHALL have outputs stall_cycles, flush_events  out  CNT_W  performance counters (see Configuration).

Function
REQ-014 freeze SHALL be MEM_req & ~MEM_ready.
REQ-015 load_use SHALL be EX_MemRead & EX_RegWrite & (EX_rd != 0) & ((ID_use_rs1 & ID_rs1==EX_rd) | (ID_use_rs2 & ID_rs2==EX_rd)).
REQ-016 Priority SHALL be freeze > EX_redirect > load_use; all controls are combinational, same-cycle.
REQ-017 On freeze: PC_stall, IFID_stall, IDEX_stall, EXMEM_stall and MEMWB_flush SHALL be 1; IFID_flush and IDEX_flush SHALL be 0.
REQ-018 On redirect without freeze: IFID_flush and IDEX_flush SHALL be 1, all stalls 0; a coincident load_use SHALL be ignored (ID instruction squashed).
REQ-019 On load_use alone: PC_stall, IFID_stall and IDEX_flush SHALL be 1 for exactly that cycle; the load advances to MEM, and forwarding from MEM/WB resolves the operand.
REQ-020 With no condition active, all control outputs SHALL be 0.
REQ-021 The FSM SHALL have states RUN and MEMWAIT; RUN->MEMWAIT when freeze; MEMWAIT->RUN on the first cycle MEM_ready=1 (freeze deasserts that same cycle).
REQ-022 A wait counter SHALL clear on entering MEMWAIT, increment each MEMWAIT cycle with freeze=1, and saturate at TIMEOUT.
REQ-023 When the wait counter reaches TIMEOUT, mem_err SHALL set on the next edge and stay 1 until rst; the freeze continues until MEM_ready.
REQ-024 MEM_req dropping while in MEMWAIT SHALL return the FSM to RUN without setting mem_err.
REQ-025 A redirect arriving during freeze SHALL NOT produce flushes until the freeze ends, since EX is held and EX_redirect is re-presented.

Reset
REQ-026 While rst=1: state RUN, wait counter 0, mem_err 0, counters 0, and all control outputs forced to 0 regardless of inputs.
REQ-027 rst asserted mid-MEMWAIT SHALL abort the wait; the first cycle after rst deasserts is evaluated from RUN.

Configuration
REQ-028 Macro HAZARD_PERF_CNT_EN defined: stall_cycles SHALL increment on every cycle with PC_stall=1, and flush_events on every cycle with IDEX_flush=1; both saturate at all-ones.
REQ-029 Macro HAZARD_PERF_CNT_EN undefined: stall_cycles and flush_events SHALL be constant 0 and no counter registers are synthesized.

Verification
REQ-030 EX load x5 (EX_MemRead=1, EX_RegWrite=1, EX_rd=5), ID rs1=5, use_rs1=1 -> PC_stall=IFID_stall=IDEX_flush=1 for 1 cycle, all 0 the next cycle.
REQ-031 Same scenario with EX_rd=0, or with use_rs1=0 -> no stall.
REQ-032 load_use plus EX_redirect in the same cycle -> IFID_flush=IDEX_flush=1 and PC_stall=0.
REQ-033 MEM_req=1 with MEM_ready=0 for 3 cycles, then 1 -> freeze outputs 1 for 3 cycles, 0 on the ready cycle, FSM returns to RUN, mem_err=0.
REQ-034 TIMEOUT=4 with MEM_ready held 0 for 10 cycles -> mem_err=1 after the 4th wait cycle and still 1 after ready; cleared only by rst.
REQ-035 HAZARD_PERF_CNT_EN defined: 3 load-use stalls plus 2 redirects -> stall_cycles=3, flush_events=5; rst pulse -> both 0.
